// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter that time-shares one registered sigmoid LUT unit among
// NUM_REQ requesters, carrying each issue's requester ID alongside the unit latency.
module sigmoid_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int SIG_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           sig_in,
  input  logic [15:0]           sig_out,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy
);

  // One extra stage covers the sig_in register in front of the unit.
  localparam int DEPTH = SIG_LAT + 1;

  logic [IDW-1:0]            ptr_reg, ptr_next;
  logic                      grant_found;
  logic [IDW-1:0]            grant_id;
  logic [15:0]               sig_in_reg, sig_in_next;
  logic [DEPTH-1:0]          tag_valid_reg, tag_valid_next;
  logic [DEPTH-1:0][IDW-1:0] tag_id_reg, tag_id_next;
  logic                      rsp_valid_reg;
  logic [IDW-1:0]            rsp_id_reg;
  logic [15:0]               rsp_data_reg;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NUM_REQ)) sum = sum - 32'(NUM_REQ);
    return sum[IDW-1:0];
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && !grant_found && req_valid[wrap_add(ptr_reg, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_add(ptr_reg, k);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_found && (grant_id == IDW'(gi));
  end

  assign ptr_next    = grant_found ? wrap_add(grant_id, 1) : ptr_reg;
  assign sig_in_next = grant_found ? req_data[16*grant_id +: 16] : sig_in_reg;

  // Tag pipe: a bubble (valid=0) enters whenever nothing is granted.
  assign tag_valid_next[0] = grant_found;
  assign tag_id_next[0]    = grant_id;
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
    assign tag_valid_next[gi] = tag_valid_reg[gi-1];
    assign tag_id_next[gi]    = tag_id_reg[gi-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      sig_in_reg    <= '0;
      tag_valid_reg <= '0;
      tag_id_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      sig_in_reg    <= sig_in_next;
      tag_valid_reg <= tag_valid_next;
      tag_id_reg    <= tag_id_next;
      rsp_valid_reg <= tag_valid_reg[DEPTH-1];
      if (tag_valid_reg[DEPTH-1]) begin
        rsp_id_reg   <= tag_id_reg[DEPTH-1];
        rsp_data_reg <= sig_out;
      end
    end
  end

  assign sig_in    = sig_in_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = |tag_valid_reg;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter with a one-cycle registered sigmoid LUT model
// holding only the operand values used by the stimulus.
module tb_sigmoid_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*16-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           sig_in;
  logic [15:0]           sig_out = '0;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           rsp_data;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;

  sigmoid_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .SIG_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sig_in(sig_in), .sig_out(sig_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sig_lut(input logic [15:0] x);
    case (x)
      16'h0000: return 16'h0080;
      16'h0100: return 16'h00BB;
      16'hFF00: return 16'h0045;
      16'h0200: return 16'h00E1;
      16'h0700: return 16'h0100;
      16'hF900: return 16'h0000;
      default:  return 16'h5A5A;
    endcase
  endfunction

  // Shared sigmoid unit: sig_out follows sig_in after one clock.
  always @(posedge clk) sig_out <= sig_lut(sig_in);

  always @(negedge clk) begin
    if (rst_n && |(req_valid & req_ready)) $display("grant ready=%b t=%0t", req_ready, $time);
    if (rst_n && rsp_valid) $display("rsp id=%0d data=%h t=%0t", rsp_id, rsp_data, $time);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_data = '0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_data = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_cmp++; if (sig_in !== 16'h0) begin n_err++; $display("FAIL reset_sig_in: got %h expected 0000", sig_in); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    n_cmp++; if (rsp_data !== 16'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0001; req_data[15:0] = 16'h0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    next_cycle(); req_valid = '0;
    @(negedge clk);
    n_cmp++; if (sig_in !== 16'h0100) begin n_err++; $display("FAIL single_sig_in: got %h expected 0100", sig_in); end
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_c1: got busy=%b rsp_valid=%b expected 1/0", busy, rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_c2: got busy=%b rsp_valid=%b expected 1/0", busy, rsp_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h00BB) begin n_err++; $display("FAIL single_rsp: got v=%b id=%0d d=%h expected 1/0/00bb", rsp_valid, rsp_id, rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_c3: got %b expected 0", busy); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_strobe: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [15:0] dat [4];
    logic [3:0]  exp_rdy;
    int          rid;
    dat = '{16'h0000, 16'h0100, 16'hFF00, 16'h0200};
    do_reset();
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = dat[i];
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      exp_rdy   = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL contention_ready c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      if (c >= 3) begin
        rid = (c - 3) % 4;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(rid) || rsp_data !== sig_lut(dat[rid])) begin
          n_err++; $display("FAIL contention_rsp c%0d: got v=%b id=%0d d=%h expected 1/%0d/%h", c, rsp_valid, rsp_id, rsp_data, rid, sig_lut(dat[rid]));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = 4'b1010;
      exp_rdy   = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fairness c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      next_cycle();
    end
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_en_drain;
    logic [3:0] exp_rdy [7];
    logic       exp_rv  [7];
    logic       exp_bsy [7];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
    exp_rv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_bsy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    req_data[15:0] = 16'h0700; req_data[31:16] = 16'hF900;
    for (int c = 0; c < 7; c++) begin
      en = (c < 2 || c >= 5);
      req_valid = 4'b0011;
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_rdy[c]) begin n_err++; $display("FAIL en_ready c%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
      n_cmp++; if (rsp_valid !== exp_rv[c]) begin n_err++; $display("FAIL en_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rv[c]); end
      n_cmp++; if (busy !== exp_bsy[c]) begin n_err++; $display("FAIL en_busy c%0d: got %b expected %b", c, busy, exp_bsy[c]); end
      if (c == 3) begin
        n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== 16'h0100) begin n_err++; $display("FAIL en_rsp0: got id=%0d d=%h expected 0/0100", rsp_id, rsp_data); end
      end
      if (c == 4) begin
        n_cmp++; if (rsp_id !== 2'd1 || rsp_data !== 16'h0000) begin n_err++; $display("FAIL en_rsp1: got id=%0d d=%h expected 1/0000", rsp_id, rsp_data); end
      end
      next_cycle();
    end
    en = 1'b1; req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    req_data[15:0] = 16'h0100; req_data[31:16] = 16'h0200; req_data[47:32] = 16'hFF00;
    req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_g0: got %b expected 0001", req_ready); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rstmid_g1: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid = '0; rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got rsp_valid=%b busy=%b expected 0/0", rsp_valid, busy); end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet c%0d: got rsp_valid=%b busy=%b expected 0/0", c, rsp_valid, busy); end
      next_cycle();
    end
    req_valid = 4'b0110;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rstmid_first: got %b expected 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    req_valid = 4'b0100; req_data[47:32] = 16'h0700;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL b2b_g0: got %b expected 0100", req_ready); end
    next_cycle();
    req_data[47:32] = 16'hF900;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL b2b_g1: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h0100) begin n_err++; $display("FAIL b2b_rsp0: got v=%b id=%0d d=%h expected 1/2/0100", rsp_valid, rsp_id, rsp_data); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h0000) begin n_err++; $display("FAIL b2b_rsp1: got v=%b id=%0d d=%h expected 1/2/0000", rsp_valid, rsp_id, rsp_data); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b expected 0", rsp_valid); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_en_drain();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
Shares one registered sigmoid LUT unit (Q8.8 in, Q8.8 out, 0x0100 = 1.0) among NUM_REQ neuron requesters. Grants are round-robin, with one issue per cycle. The block registers the operand into the unit, tracks each in-flight request's ID through the unit latency, and returns the result tagged with the requester ID. It sits between the neuron accumulators and the shared activation unit in each layer.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDW, 2, width of requester ID; must equal ceil(log2(NUM_REQ))
SIG_LAT, 1, cycles from sig_in change to valid sig_out in the shared sigmoid unit

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; when 0, no new grants, in-flight ops drain
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  NUM_REQ*16  per-requester Q8.8 operand; requester i uses bits [16i+15:16i]
req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
sig_in  out  16  registered operand to the shared sigmoid unit
sig_out  in  16  result from the shared sigmoid unit
rsp_valid  out  1  single-cycle result strobe; sink always accepts
rsp_id  out  IDW  requester ID of the result
rsp_data  out  16  Q8.8 sigmoid result
busy  out  1  high while any accepted op has not yet produced rsp_valid

Behaviour:
- Reset (async, rst_n=0):
  - sig_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - RR pointer=0; all in-flight tags cleared.
  - Ops in flight at reset are discarded and never respond.
- Arbitration (combinational):
  - When en=1, req_ready asserts for the first i with req_valid[i]=1, searching upward from the pointer with wrap at NUM_REQ.
  - At most one req_ready bit is high; all are 0 when en=0 or no req_valid is set.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On a handshake for requester g at edge E0:
  - sig_in <= req_data[g].
  - Issue tag {valid=1, id=g} enters the tag pipe.
  - Pointer <= (g+1) mod NUM_REQ.
- No handshake: sig_in holds its last value, a valid=0 tag enters the pipe, and the pointer holds.
- Tag pipe is SIG_LAT+1 stages deep, so the tag aligns with sig_out SIG_LAT cycles after sig_in is updated.
- Response register: when the aligned tag is valid, it captures rsp_data<=sig_out and rsp_id<=tag id, and sets rsp_valid=1 for exactly one cycle. Otherwise rsp_valid=0 and rsp_data/rsp_id hold.
- Latency with SIG_LAT=1: handshake in cycle 0, sig_in visible cycle 1, sig_out valid cycle 2, rsp_valid cycle 3. This is fixed and independent of contention.
- Throughput: one op per cycle, fully pipelined; responses return in grant order.
- busy: OR of all tag-pipe valid bits. It does not include the response register or the current-cycle grant.
- en falling mid-stream: grants stop in that same cycle. Accepted ops still complete, and busy falls after the last one leaves the tag pipe.
- The pointer advances only on a grant. A requester holding req_valid waits at most NUM_REQ-1 grants.
- No arithmetic is done on operands; the 16-bit data passes unmodified.

Test Plan:
1. Single op: req_valid=0001, req_data[0]=0x0100 at cycle 0 -> req_ready=0001 in cycle 0; sig_in=0x0100 in cycle 1; rsp_valid=1, rsp_id=0, rsp_data=0x00BB in cycle 3; busy=1 in cycles 1-2.
2. Full contention: all four valid continuously after reset with data 0x0000, 0x0100, 0xFF00, 0x0200 -> grants 0,1,2,3,0,... one per cycle. Responses start cycle 3 with ids 0,1,2,3 and data 0x0080, 0x00BB, 0x0045, 0x00E1.
3. Fairness: pointer=0, req1 and req3 held valid -> grant order 1,3,1,3; req0/req2 never granted; no gaps.
4. en=0 for 3 cycles with req0..1 valid, right after grants to 0 and 1 -> no req_ready during en=0. Both in-flight results still arrive. busy drops, and resumed grants start from pointer=2 and wrap to 0.
5. Reset mid-flight: rst_n low one cycle after two grants -> rsp_valid=0 and busy=0 immediately. No response appears after release; the first grant goes to the lowest valid ID.
6. Saturation back-to-back: req2 alone sends 0x0700 then 0xF900 -> consecutive rsp_valid with id 2, data 0x0100 then 0x0000.
